// File: rtl/capture_buffer_if.sv
// Probe/trigger/readout bundle between the logic-analyzer host side and capture_buffer.
interface capture_buffer_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] d;
  logic             arm;
  logic [WIDTH-1:0] trig_mask;
  logic [WIDTH-1:0] trig_val;
  logic             rd_en;
  logic             busy;
  logic             triggered;
  logic             done;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;

  modport master (
    output en, d, arm, trig_mask, trig_val, rd_en,
    input  busy, triggered, done, rd_data, rd_valid
  );

  modport slave (
    input  en, d, arm, trig_mask, trig_val, rd_en,
    output busy, triggered, done, rd_data, rd_valid
  );
endinterface

// File: rtl/capture_buffer.sv
// Logic-analyzer capture: circular pre-trigger history, mask/value trigger, fixed post window, oldest-first readout.
// Define TRIG_EDGE_EN to trigger on a false->true transition of the match instead of its level.
module capture_buffer #(
  parameter int WIDTH = 8,
  parameter int AW    = 4,
  parameter int PRE   = 4
) (
  input logic             clk,
  input logic             rs,
  capture_buffer_if.slave bus
);
  localparam int DEPTH = 2 ** AW;
  localparam int POST  = DEPTH - PRE - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_FILL,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_trig_addr;
  logic             r_busy;
  logic             r_triggered;
  logic             r_done;
  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_match;
  logic             w_trig;
  logic             w_capturing;
  logic             w_wr;
  logic [AW-1:0]    w_wr_ptr_nxt;
  logic [AW-1:0]    w_cnt_nxt;

  assign w_match      = ((bus.d ^ bus.trig_val) & bus.trig_mask) == '0;
  assign w_capturing  = (r_state == S_PRE_FILL) || (r_state == S_WAIT_TRIG) || (r_state == S_POST);
  assign w_wr         = w_capturing && bus.en;
  assign w_wr_ptr_nxt = r_wr_ptr + 1'b1;
  assign w_cnt_nxt    = r_cnt + 1'b1;

`ifdef TRIG_EDGE_EN
  logic r_match_q;

  // Previous sample's match; restarts from "no match" on every arm so a held condition must drop first.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      r_match_q <= 1'b0;
    end else if (((r_state == S_IDLE) || (r_state == S_DONE)) && bus.arm) begin
      r_match_q <= 1'b0;
    end else if (((r_state == S_PRE_FILL) || (r_state == S_WAIT_TRIG)) && bus.en) begin
      r_match_q <= w_match;
    end
  end

  assign w_trig = w_match & ~r_match_q;
`else
  assign w_trig = w_match;
`endif

  // Sample storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.d;
    end
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_rd_ptr    <= '0;
      r_trig_addr <= '0;
      r_busy      <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_wr) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.arm) begin
            r_state     <= S_PRE_FILL;
            r_cnt       <= '0;
            r_triggered <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_PRE_FILL: begin
          if (bus.en) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == AW'(PRE)) begin
              r_state <= S_WAIT_TRIG;
            end
          end
        end
        S_WAIT_TRIG: begin
          if (bus.en && w_trig) begin
            r_trig_addr <= r_wr_ptr;
            r_triggered <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_POST;
          end
        end
        S_POST: begin
          if (bus.en) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == AW'(POST)) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              // Oldest stored sample; equals the write pointer after this final write.
              r_rd_ptr <= r_trig_addr - AW'(PRE);
            end
          end
        end
        S_DONE: begin
          if (bus.arm) begin
            r_state     <= S_PRE_FILL;
            r_cnt       <= '0;
            r_triggered <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end else if (bus.rd_en) begin
            r_rd_data  <= r_mem[r_rd_ptr];
            r_rd_valid <= 1'b1;
            r_rd_ptr   <= r_rd_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.triggered = r_triggered;
  assign bus.done      = r_done;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer: directed scenarios plus randomized captures against a queue-based model.
module tb_capture_buffer;
  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int PRE   = 4;
  localparam int DEPTH = 16;
  localparam int POST  = DEPTH - PRE - 1;

  logic clk = 1'b0;
  logic rs;
  int   n_chk  = 0;
  int   n_fail = 0;

  capture_buffer_if #(.WIDTH(WIDTH)) bus ();

  capture_buffer #(.WIDTH(WIDTH), .AW(AW), .PRE(PRE)) dut (
    .clk (clk),
    .rs  (rs),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: phase 0 idle, 1 pre-fill, 2 wait trigger, 3 post, 4 done.
  int         m_phase;
  int         m_post;
  int         m_rd_idx;
  logic [7:0] m_hist[$];
  logic [7:0] m_win[DEPTH];
  logic       m_trig;
  logic       m_rdv;
  logic [7:0] m_rdd;
  logic       m_mq;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic model_match(input logic [7:0] d);
    return ((d ^ bus.trig_val) & bus.trig_mask) == 8'h00;
  endfunction

  task automatic model_start();
    m_phase = 1;
    m_hist.delete();
    m_trig = 1'b0;
    m_mq   = 1'b0;
  endtask

  task automatic model_edge();
    logic mt;
    logic fire;
    mt   = model_match(bus.d);
    m_rdv = 1'b0;
    case (m_phase)
      0: if (bus.arm) model_start();
      4: begin
        if (bus.arm) model_start();
        else if (bus.rd_en) begin
          m_rdd = m_win[m_rd_idx % DEPTH];
          m_rd_idx++;
          m_rdv = 1'b1;
        end
      end
      1: if (bus.en) begin
        m_hist.push_back(bus.d);
        m_mq = mt;
        if (m_hist.size() >= PRE) m_phase = 2;
      end
      2: if (bus.en) begin
        m_hist.push_back(bus.d);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
`ifdef TRIG_EDGE_EN
        fire = mt && !m_mq;
`else
        fire = mt;
`endif
        m_mq = mt;
        if (fire) begin
          m_trig  = 1'b1;
          m_post  = 0;
          m_phase = 3;
        end
      end
      3: if (bus.en) begin
        m_hist.push_back(bus.d);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
        m_post++;
        if (m_post == POST) begin
          for (int i = 0; i < DEPTH; i++) m_win[i] = m_hist[m_hist.size() - DEPTH + i];
          m_rd_idx = 0;
          m_phase  = 4;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    chk1({tag, "_busy"}, bus.busy, (m_phase >= 1) && (m_phase <= 3));
    chk1({tag, "_done"}, bus.done, m_phase == 4);
    chk1({tag, "_triggered"}, bus.triggered, m_trig);
    chk1({tag, "_rd_valid"}, bus.rd_valid, m_rdv);
    chk8({tag, "_rd_data"}, bus.rd_data, m_rdd);
  endtask

  task automatic step(input logic en, input logic [7:0] d, input logic arm, input logic rd_en);
    bus.en    = en;
    bus.d     = d;
    bus.arm   = arm;
    bus.rd_en = rd_en;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs("step");
  endtask

  task automatic do_reset();
    rs = 1'b1;
    #2;
    m_phase = 0;
    m_trig  = 1'b0;
    m_rdv   = 1'b0;
    m_rdd   = 8'h00;
    m_mq    = 1'b0;
    m_hist.delete();
    check_outputs("reset_async");
    @(posedge clk);
    #1;
    rs = 1'b0;
    check_outputs("reset_release");
  endtask

  // en_mode: 0 always, 1 alternating, 2 random with random data and arm/rd_en noise.
  task automatic run_capture(input logic [7:0] mask, input logic [7:0] val, input int en_mode,
                             input int abort_post);
    logic [7:0] cnt;
    logic       en;
    logic [7:0] dv;
    bus.trig_mask = mask;
    bus.trig_val  = val;
    cnt = 8'h00;
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    for (int c = 0; c < 600 && m_phase != 4; c++) begin
      if (en_mode == 0) en = 1'b1;
      else if (en_mode == 1) en = (c % 2 == 0);
      else en = ($urandom_range(0, 3) != 0);
      if (!en) dv = 8'($urandom);
      else if (en_mode == 2) dv = 8'($urandom_range(0, 15));
      else begin
        dv  = cnt;
        cnt = cnt + 8'h01;
      end
      step(en, dv, (en_mode == 2) && ($urandom_range(0, 15) == 0),
           (en_mode == 2) && ($urandom_range(0, 7) == 0));
      if (abort_post >= 0 && m_phase == 3 && m_post == abort_post) begin
        do_reset();
        return;
      end
    end
    chk1("done_reached", bus.done, 1'b1);
  endtask

  task automatic read_n(input int n, input int base, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'($urandom), 1'b0, 1'b1);
      if (base >= 0) begin
        chk8(tag, bus.rd_data, 8'(base + (i % DEPTH)));
        chk1({tag, "_vld"}, bus.rd_valid, 1'b1);
      end
    end
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.d         = 8'h00;
    bus.arm       = 1'b0;
    bus.rd_en     = 1'b0;
    bus.trig_mask = 8'h00;
    bus.trig_val  = 8'h00;
    m_rdd         = 8'h00;
    m_rd_idx      = 0;
    m_post        = 0;
    rs            = 1'b0;
    #3;
    do_reset();

    // Case 1: level trigger on 0x07, window 0x03..0x12.
    run_capture(8'hFF, 8'h07, 0, -1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk1("c1_idle_vld", bus.rd_valid, 1'b0);
    read_n(DEPTH, 8'h03, "c1_rd");

    // Case 2: match during pre-fill ignored; next occurrence 0x11 triggers.
    run_capture(8'h0F, 8'h01, 0, -1);
    read_n(DEPTH, 8'h0D, "c2_rd");
    run_capture(8'hFF, 8'h04, 0, -1);
    read_n(DEPTH, 8'h00, "c2b_rd");

    // Case 3 + 5: strobed-only capture, then 20 reads wrapping to the oldest sample.
    run_capture(8'hFF, 8'h07, 1, -1);
    read_n(20, 8'h03, "c3_rd");
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk1("c5_arm_rd_vld", bus.rd_valid, 1'b0);
    chk1("c5_rearm_busy", bus.busy, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk1("c5_busy_rd_vld", bus.rd_valid, 1'b0);
    do_reset();

    // Case 4: reset in the middle of the post window, then a clean capture.
    run_capture(8'hFF, 8'h07, 0, 5);
    chk1("c4_busy", bus.busy, 1'b0);
    chk1("c4_trig", bus.triggered, 1'b0);
    run_capture(8'hFF, 8'h07, 0, -1);
    read_n(DEPTH, 8'h03, "c4_rd");

`ifdef TRIG_EDGE_EN
    // Case 6: held match from arm must drop before it triggers.
    do_reset();
    bus.trig_mask = 8'hFF;
    bus.trig_val  = 8'h07;
    step(1'b1, 8'h07, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h07, 1'b0, 1'b0);
    chk1("c6_held_no_trig", bus.triggered, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    chk1("c6_low_no_trig", bus.triggered, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b0);
    chk1("c6_edge_trig", bus.triggered, 1'b1);
    do_reset();
`endif

    // Randomized captures with noisy strobe, data, arm and read requests.
    for (int r = 0; r < 6; r++) begin
      run_capture(8'($urandom_range(0, 255)) & 8'h0F, 8'($urandom), 2, -1);
      for (int k = 0; k < 24; k++) step(1'b0, 8'($urandom), 1'b0, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
